// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, data, optional parity and stop
// bits around an external serializer, with a watchdog on the data phase.
module uart_tx_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WD_SLACK   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned WD_LIMIT = DATA_WIDTH + WD_SLACK;
  localparam int unsigned CNT_W    = $clog2(WD_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_par_en;
  logic               w_par_en_nxt;
  logic               r_par_bit;
  logic               w_par_bit_nxt;
  logic               r_frame_err;
  logic               w_frame_err_nxt;
  logic               w_accept;
  logic               w_done_ok;

  // State and frame-context registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_par_en    <= w_par_en_nxt;
      r_par_bit   <= w_par_bit_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state logic; ser_done only counts once at least one data bit has gone out
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_par_en_nxt    = r_par_en;
    w_par_bit_nxt   = r_par_bit;
    w_frame_err_nxt = 1'b0;
    w_accept        = 1'b0;
    w_done_ok       = ser_done && (r_cnt != '0);

    case (r_state)
      S_IDLE: begin
        if (data_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (r_cnt != CNT_W'(WD_LIMIT)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (w_done_ok) begin
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
        end else if (r_cnt >= CNT_W'(WD_LIMIT - 1)) begin
          w_state_nxt     = S_STOP;
          w_frame_err_nxt = 1'b1;
        end
      end
      S_PARITY: begin
        w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (data_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_accept) begin
      w_par_en_nxt  = par_en;
      w_par_bit_nxt = (^p_data) ^ par_typ;
    end
  end

  // Line and handshake decode from the registered state
  always_comb begin
    tx_out = 1'b1;
    busy   = 1'b1;
    ser_en = 1'b0;
    case (r_state)
      S_IDLE:   busy   = 1'b0;
      S_START:  tx_out = 1'b0;
      S_DATA: begin
        tx_out = ser_data;
        ser_en = 1'b1;
      end
      S_PARITY: tx_out = r_par_bit;
      S_STOP:   tx_out = 1'b1;
      default:  busy   = 1'b0;
    endcase
  end

  assign frame_err = r_frame_err;

endmodule
